// File: rtl/cle_label_packer.sv
// rtl/cle_label_packer.sv - packs the CLE label map into one-bit-per-pixel bytes
//
// Reads the N_PIX-entry label SRAM in address order.
// Each pixel is marked as matching or not against sel_label.
// Groups of 8 pixels are packed MSB-first into bytes, in the ROM layout.
// The number of matching pixels is counted.
//
// Ports:
//   clk, reset      rising-edge clock; synchronous active-high reset
//   start           one-cycle pass request, ignored while busy
//   sel_label       label to extract (0 = any nonzero), latched with start
//   sram_a, sram_q  label SRAM read address / data (2-edge read latency)
//   pk_a, pk_d      packed-memory write address / byte
//   pk_wen          packed-memory write enable, active low, one cycle per byte
//   pix_cnt         matched pixel count for the current/last pass
//   busy, done      pass running / pass finished (held until next start)

module cle_label_packer #(
  parameter int N_PIX = 1024,
  parameter int SA_W  = 10,
  parameter int PA_W  = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      sel_label,
  output logic [SA_W-1:0] sram_a,
  input  logic [7:0]      sram_q,
  output logic [PA_W-1:0] pk_a,
  output logic [7:0]      pk_d,
  output logic            pk_wen,
  output logic [SA_W:0]   pix_cnt,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  // Address loaded one edge before the last one, so the final address lands on the DRAIN transition.
  localparam logic [SA_W-1:0] PRE_LAST_A = SA_W'(N_PIX - 2);

  state_t          state;
  logic [7:0]      sel_r;
  logic            v1;     // sram_a currently holds a valid pass address
  logic            v2;     // sram_q currently holds data for a valid address
  logic [SA_W-1:0] cap_n;  // index of the pixel captured next
  logic [6:0]      acc;    // first seven pixels of the byte being assembled
  logic            match;

  // Written as if-statements so an unknown sram_q falls to "no match".
  always_comb begin
    match = 1'b0;
    if (sel_r == 8'd0) begin
      if (sram_q != 8'd0) match = 1'b1;
    end else if (sram_q == sel_r) begin
      match = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sram_a  <= '0;
      pk_a    <= '0;
      pk_d    <= '0;
      pk_wen  <= 1'b1;
      pix_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sel_r   <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      cap_n   <= '0;
      acc     <= '0;
    end else begin
      v2     <= v1;
      pk_wen <= 1'b1;

      // Capture stage: pixel cap_n is on sram_q this cycle.
      if (v2) begin
        cap_n <= cap_n + 1'b1;
        acc   <= {acc[5:0], match};
        if (match) pix_cnt <= pix_cnt + 1'b1;
        if (cap_n[2:0] == 3'd7) begin
          pk_a   <= cap_n[SA_W-1:3];
          pk_d   <= {acc, match};
          pk_wen <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          v1 <= 1'b0;
          if (start) begin
            state   <= READ;
            sram_a  <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pix_cnt <= '0;
            sel_r   <= sel_label;
            cap_n   <= '0;
            v1      <= 1'b1;
          end
        end
        READ: begin
          v1     <= 1'b1;
          sram_a <= sram_a + 1'b1;
          if (sram_a == PRE_LAST_A) state <= DRAIN;
        end
        DRAIN: begin
          // Address holds; wait for both in-flight reads to be captured.
          v1 <= 1'b0;
          if (!v1 && !v2) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cle_label_packer.sv
// tb/tb_cle_label_packer.sv - scoreboard bench for cle_label_packer

module tb_cle_label_packer;

  localparam int N_PIX = 1024;
  localparam int SA_W  = 10;
  localparam int PA_W  = 7;
  localparam int N_BYTES = N_PIX / 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      sel_label = 8'd0;
  logic [SA_W-1:0] sram_a;
  logic [7:0]      sram_q = 8'd0;
  logic [PA_W-1:0] pk_a;
  logic [7:0]      pk_d;
  logic            pk_wen;
  logic [SA_W:0]   pix_cnt;
  logic            busy;
  logic            done;

  cle_label_packer #(.N_PIX(N_PIX), .SA_W(SA_W), .PA_W(PA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .sel_label(sel_label),
    .sram_a(sram_a), .sram_q(sram_q), .pk_a(pk_a), .pk_d(pk_d),
    .pk_wen(pk_wen), .pix_cnt(pix_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [N_PIX];

  always @(posedge clk) sram_q <= mem[sram_a];

  int total = 0;
  int bad = 0;
  int writes_seen = 0;
  logic [14:0] exp_q[$];  // {addr, data}

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe is matched against the next expected byte.
  always @(negedge clk) begin
    if (!reset && pk_wen === 1'b0) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=%0d/%02h required=none", pk_a, pk_d);
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        total++;
        if ({pk_a, pk_d} !== e) begin
          bad++;
          $display("FAIL write actual=%0d/%02h required=%0d/%02h", pk_a, pk_d, e[14:8], e[7:0]);
        end
      end
    end
  end

  // Reference model: pixel-by-pixel selection, byte-level packing, direct count.
  int exp_cnt;
  task automatic build_expect(input logic [7:0] sel);
    exp_q.delete();
    exp_cnt = 0;
    for (int b = 0; b < N_BYTES; b++) begin
      int byte_val;
      byte_val = 0;
      for (int k = 0; k < 8; k++) begin
        int p;
        bit hit;
        p = mem[b * 8 + k];
        hit = (sel == 0) ? (p != 0) : (p == sel);
        if (hit) begin
          byte_val += 1 << (7 - k);
          exp_cnt++;
        end
      end
      exp_q.push_back({7'(b), 8'(byte_val)});
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < N_PIX; i++) mem[i] = v;
  endtask

  // mode 0: plain pass, 1: extra start pulses at cycles 10 and 600, 2: reset at cycle 500
  task automatic run_pass(input string tag, input logic [7:0] sel, input int mode);
    int k;
    build_expect(sel);
    writes_seen = 0;
    @(negedge clk);
    start = 1'b1;
    sel_label = sel;
    @(negedge clk);  // E0 has occurred
    start = 1'b0;
    sel_label = ~sel;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_done_after_start"}, done, 0);
    k = 0;
    while (!done && k < 2000) begin
      if (mode == 1 && (k == 10 || k == 600)) begin
        start = 1'b1;
        sel_label = sel ^ 8'h5A;
      end else begin
        start = 1'b0;
      end
      if (mode == 2 && k == 500) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check({tag, "_rst_pk_wen"}, pk_wen, 1);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_done"}, done, 0);
        check({tag, "_rst_pix_cnt"}, pix_cnt, 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        check({tag, "_rst_done_stays_0"}, done, 0);
        return;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, "_done_edge"}, k, N_PIX + 2);
    check({tag, "_pix_cnt"}, pix_cnt, exp_cnt);
    check({tag, "_writes"}, writes_seen, N_BYTES);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_busy_end"}, busy, 0);
    repeat (3) @(negedge clk);
    check({tag, "_done_held"}, done, 1);
    check({tag, "_pix_cnt_stable"}, pix_cnt, exp_cnt);
    check({tag, "_no_late_write"}, writes_seen, N_BYTES);
  endtask

  initial begin
    fill_const(8'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_sram_a", sram_a, 0);
    check("reset_pk_a", pk_a, 0);
    check("reset_pk_d", pk_d, 0);
    check("reset_pk_wen", pk_wen, 1);
    check("reset_pix_cnt", pix_cnt, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    fill_const(8'd0);
    run_pass("zeros", 8'd0, 0);

    fill_const(8'd1);
    run_pass("ones", 8'd0, 0);

    fill_const(8'd0);
    mem[0] = 8'd3;
    mem[N_PIX - 1] = 8'd3;
    run_pass("corners_sel3", 8'd3, 0);
    check("corners_sel3_cnt_const", pix_cnt, 2);
    run_pass("corners_sel4", 8'd4, 0);

    fill_const(8'd0);
    for (int i = 0; i < 32; i++) mem[i] = (i % 2 == 0) ? 8'd2 : 8'd5;
    run_pass("row0_sel2", 8'd2, 0);
    run_pass("row0_sel0", 8'd0, 0);

    for (int i = 0; i < N_PIX; i++) mem[i] = 8'($urandom_range(0, 3));
    run_pass("restart_ignored", 8'd2, 1);

    fill_const(8'd1);
    run_pass("reset_mid", 8'd0, 2);
    run_pass("after_reset", 8'd0, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N_PIX; i++)
        mem[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 4)) : 8'd0;
      run_pass("random", 8'($urandom_range(0, 4)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
